serializer_lanes: RTL and testbench

Parametrised successor of the single-bit serializer. Accepts parallel words over a valid/ready handshake and shifts each word out over LANES serial lanes, one slice per cycle, MSB-first or LSB-first per word. A one-entry holding register allows back-to-back words with no idle cycle between packets. Sits between a parallel producer and a framed serial link that uses enable/start/last strobes.

---
 rtl/serializer_lanes.sv | 147 ++++++++++++++
 tb/tb_serializer_lanes.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serializer_lanes.sv
// Multi-lane word serializer: parallel words in over valid/ready, LANES bits per beat out,
// with a one-entry holding register so consecutive words stream without idle beats.
module serializer_lanes #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [DATA_WIDTH-1:0] parallel_in_i,
    input  logic                  lsb_first_i,
    input  logic                  valid_in_i,
    output logic                  ready_o,
    output logic [LANES-1:0]      serial_out_o,
    output logic                  enable_o,
    output logic                  start_o,
    output logic                  last_o,
    output logic                  busy_o
);

    localparam int BEATS = DATA_WIDTH / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    // Shifter state: the word currently on the lanes and the beat index being shown.
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic                  order_q, order_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  active_q, active_d;

    logic                  hold_valid_q, hold_valid_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic                  hold_order_q, hold_order_d;

    logic [LANES-1:0]      serial_q, serial_d;
    logic                  enable_q, enable_d;
    logic                  start_q, start_d;
    logic                  last_q, last_d;
    logic                  busy_q, busy_d;

    logic                  load_pt;
    logic                  accept;

    function automatic logic [LANES-1:0] slice_f(
        input logic [DATA_WIDTH-1:0] word,
        input logic                  lsb,
        input logic [CNT_W-1:0]      beat
    );
        logic [DATA_WIDTH-1:0] shifted;
        int                    shamt;
        if (lsb) begin
            shamt = int'(beat) * LANES;
        end else begin
            shamt = DATA_WIDTH - (int'(beat) + 1) * LANES;
        end
        shifted = word >> shamt;
        return shifted[LANES-1:0];
    endfunction

    assign ready_o = !hold_valid_q;
    assign accept  = valid_in_i && !hold_valid_q;
    assign load_pt = !active_q || (cnt_q == LAST_BEAT);

    always_comb begin
        word_d       = word_q;
        order_d      = order_q;
        cnt_d        = cnt_q;
        active_d     = active_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        hold_order_d = hold_order_q;

        if (load_pt) begin
            cnt_d = '0;
            if (hold_valid_q) begin
                active_d     = 1'b1;
                word_d       = hold_data_q;
                order_d      = hold_order_q;
                hold_valid_d = 1'b0;
                if (accept) begin
                    hold_valid_d = 1'b1;
                    hold_data_d  = parallel_in_i;
                    hold_order_d = lsb_first_i;
                end
            end else if (accept) begin
                // Idle or finishing shifter takes the new word directly, bypassing the hold.
                active_d = 1'b1;
                word_d   = parallel_in_i;
                order_d  = lsb_first_i;
            end else begin
                active_d = 1'b0;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (accept) begin
                hold_valid_d = 1'b1;
                hold_data_d  = parallel_in_i;
                hold_order_d = lsb_first_i;
            end
        end
    end

    // Outputs are computed from next state so every port comes straight from a flop.
    always_comb begin
        enable_d = active_d;
        serial_d = active_d ? slice_f(word_d, order_d, cnt_d) : '0;
        start_d  = active_d && (cnt_d == '0);
        last_d   = active_d && (cnt_d == LAST_BEAT);
        busy_d   = active_d || hold_valid_d;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            word_q       <= '0;
            order_q      <= 1'b0;
            cnt_q        <= '0;
            active_q     <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            hold_order_q <= 1'b0;
            serial_q     <= '0;
            enable_q     <= 1'b0;
            start_q      <= 1'b0;
            last_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            word_q       <= word_d;
            order_q      <= order_d;
            cnt_q        <= cnt_d;
            active_q     <= active_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            hold_order_q <= hold_order_d;
            serial_q     <= serial_d;
            enable_q     <= enable_d;
            start_q      <= start_d;
            last_q       <= last_d;
            busy_q       <= busy_d;
        end
    end

    assign serial_out_o = serial_q;
    assign enable_o     = enable_q;
    assign start_o      = start_q;
    assign last_o       = last_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_serializer_lanes.sv
// Scoreboard bench for serializer_lanes: three instances (8x1, 32x4, 8x8) share clock and reset.
module tb_serializer_lanes;

    logic clk;
    logic rst_n;

    logic [7:0]  a_din;  logic a_lsb, a_vld, a_rdy, a_en, a_st, a_la, a_bz; logic [0:0] a_so;
    logic [31:0] b_din;  logic b_lsb, b_vld, b_rdy, b_en, b_st, b_la, b_bz; logic [3:0] b_so;
    logic [7:0]  c_din;  logic c_lsb, c_vld, c_rdy, c_en, c_st, c_la, c_bz; logic [7:0] c_so;

    serializer_lanes #(.DATA_WIDTH(8), .LANES(1)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .parallel_in_i(a_din), .lsb_first_i(a_lsb),
        .valid_in_i(a_vld), .ready_o(a_rdy), .serial_out_o(a_so), .enable_o(a_en),
        .start_o(a_st), .last_o(a_la), .busy_o(a_bz));

    serializer_lanes #(.DATA_WIDTH(32), .LANES(4)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .parallel_in_i(b_din), .lsb_first_i(b_lsb),
        .valid_in_i(b_vld), .ready_o(b_rdy), .serial_out_o(b_so), .enable_o(b_en),
        .start_o(b_st), .last_o(b_la), .busy_o(b_bz));

    serializer_lanes #(.DATA_WIDTH(8), .LANES(8)) dut_c (
        .clk_i(clk), .rst_n_i(rst_n), .parallel_in_i(c_din), .lsb_first_i(c_lsb),
        .valid_in_i(c_vld), .ready_o(c_rdy), .serial_out_o(c_so), .enable_o(c_en),
        .start_o(c_st), .last_o(c_la), .busy_o(c_bz));

    typedef struct {
        logic [31:0] data;
        logic        st;
        logic        la;
    } beat_t;

    beat_t sbq [3][$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    en_cnt [3];
    int    first_en [3];
    int    last_en [3];
    int    acc_cyc [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int id);
        case (id)
            0:       return a_rdy;
            1:       return b_rdy;
            default: return c_rdy;
        endcase
    endfunction

    function automatic logic bz(input int id);
        case (id)
            0:       return a_bz;
            1:       return b_bz;
            default: return c_bz;
        endcase
    endfunction

    task automatic drive(input int id, input logic [31:0] w, input logic lsb, input logic v);
        case (id)
            0: begin a_din = w[7:0]; a_lsb = lsb; a_vld = v; end
            1: begin b_din = w;      b_lsb = lsb; b_vld = v; end
            default: begin c_din = w[7:0]; c_lsb = lsb; c_vld = v; end
        endcase
    endtask

    // Reference model of the lane slicing, independent of the RTL's structure.
    task automatic push_word(input int id, input logic [31:0] w, input logic lsb);
        int    wd, ln, beats, shamt;
        beat_t b;
        wd    = (id == 1) ? 32 : 8;
        ln    = (id == 0) ? 1 : ((id == 1) ? 4 : 8);
        beats = wd / ln;
        for (int k = 0; k < beats; k++) begin
            shamt  = lsb ? k * ln : wd - (k + 1) * ln;
            b.data = (w >> shamt) & ((32'h1 << ln) - 32'h1);
            b.st   = (k == 0);
            b.la   = (k == beats - 1);
            sbq[id].push_back(b);
        end
    endtask

    task automatic send(input int id, input logic [31:0] w, input logic lsb);
        int n = 0;
        drive(id, w, lsb, 1'b1);
        @(negedge clk);
        while (!rdy(id) && n < 100) begin
            n++;
            @(negedge clk);
        end
        check($sformatf("accept_wait%0d", id), 32'(n < 100), 32'd1);
        if (n < 100) begin
            acc_cyc[id] = cyc;
            push_word(id, w, lsb);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic release_valid(input int id);
        drive(id, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic wait_drain(input int id);
        int n = 0;
        while ((sbq[id].size() != 0 || bz(id)) && n < 500) begin
            n++;
            @(negedge clk);
        end
        check($sformatf("drain%0d", id), 32'(n < 500), 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic reset_stats(input int id);
        en_cnt[id]   = 0;
        first_en[id] = -1;
        last_en[id]  = 0;
    endtask

    task automatic mon(input int id, input logic en, input logic [31:0] so, input logic st, input logic la);
        beat_t b;
        if (en) begin
            en_cnt[id]++;
            if (first_en[id] < 0) first_en[id] = cyc;
            last_en[id] = cyc;
            if (sbq[id].size() == 0) begin
                check($sformatf("unexpected_beat%0d", id), 32'd1, 32'd0);
            end else begin
                b = sbq[id].pop_front();
                check($sformatf("slice%0d", id), so, b.data);
                check($sformatf("start%0d", id), 32'(st), 32'(b.st));
                check($sformatf("last%0d", id), 32'(la), 32'(b.la));
            end
        end else begin
            check($sformatf("idle_quiet%0d", id), 32'(so != 0 || st || la), 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, a_en, 32'(a_so), a_st, a_la);
            mon(1, b_en, 32'(b_so), b_st, b_la);
            mon(2, c_en, 32'(c_so), c_st, c_la);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            release_valid(i);
            reset_stats(i);
            acc_cyc[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_outs_a", {28'd0, a_en, a_st, a_la, a_so}, 32'd0);
        check("rst_busy_a", 32'(a_bz), 32'd0);
        check("rst_outs_b", {b_so, b_en, b_st, b_la, b_bz}, 32'd0);
        check("rst_outs_c", {c_so, c_en, c_st, c_la, c_bz}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rdy_after_rst", {29'd0, a_rdy, b_rdy, c_rdy}, 32'd7);

        // 0xA5 MSB-first on one lane, latency and beat count
        reset_stats(0);
        send(0, 32'hA5, 1'b0);
        release_valid(0);
        wait_drain(0);
        check("msb_beats", 32'(en_cnt[0]), 32'd8);
        check("msb_latency", 32'(first_en[0] - acc_cyc[0]), 32'd1);
        check("msb_span", 32'(last_en[0] - first_en[0] + 1), 32'd8);

        // Same word LSB-first
        reset_stats(0);
        send(0, 32'hA5, 1'b1);
        release_valid(0);
        wait_drain(0);
        check("lsb_beats", 32'(en_cnt[0]), 32'd8);

        // Four lanes, both orders
        reset_stats(1);
        send(1, 32'h12345678, 1'b0);
        release_valid(1);
        wait_drain(1);
        check("x4_beats", 32'(en_cnt[1]), 32'd8);
        w = $urandom;
        send(1, w, 1'b1);
        release_valid(1);
        wait_drain(1);

        // Back-to-back stream through the holding register
        reset_stats(0);
        send(0, 32'h11, 1'b0);
        send(0, 32'h22, 1'b0);
        check("rdy_drop_held", 32'(a_rdy), 32'd0);
        check("busy_held", 32'(a_bz), 32'd1);
        send(0, 32'h33, 1'b1);
        release_valid(0);
        wait_drain(0);
        check("b2b_beats", 32'(en_cnt[0]), 32'd24);
        check("b2b_span", 32'(last_en[0] - first_en[0] + 1), 32'd24);

        // One-beat words: one word per cycle, ready never drops
        reset_stats(2);
        for (int i = 0; i < 4; i++) begin
            w = $urandom;
            send(2, w, 1'(i & 1));
            check($sformatf("x8_rdy%0d", i), 32'(c_rdy), 32'd1);
        end
        release_valid(2);
        wait_drain(2);
        check("x8_beats", 32'(en_cnt[2]), 32'd4);
        check("x8_span", 32'(last_en[2] - first_en[2] + 1), 32'd4);

        // Asynchronous reset mid-word with a word held
        reset_stats(0);
        send(0, 32'hC3, 1'b0);
        send(0, 32'h5A, 1'b1);
        release_valid(0);
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_en", 32'(a_en), 32'd1);
        check("pre_rst_rdy", 32'(a_rdy), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_outs", {28'd0, a_en, a_st, a_la, a_so}, 32'd0);
        check("async_rst_busy", 32'(a_bz), 32'd0);
        check("async_rst_rdy", 32'(a_rdy), 32'd1);
        for (int i = 0; i < 3; i++) sbq[i].delete();
        @(negedge clk);
        rst_n = 1'b1;
        reset_stats(0);
        repeat (12) @(posedge clk);
        #1;
        check("post_rst_beats", 32'(en_cnt[0]), 32'd0);
        check("post_rst_rdy", 32'(a_rdy), 32'd1);
        check("post_rst_busy", 32'(a_bz), 32'd0);

        for (int i = 0; i < 3; i++) begin
            check($sformatf("sb_empty%0d", i), 32'(sbq[i].size()), 32'd0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
